// File: rtl/dc_window_pkg.sv
// Shared types for the DC filter window feeder: pixel word, FSM states, column word select.
package dc_window_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD0  = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TOP = 2'd0,
    MID = 2'd1,
    BOT = 2'd2
  } word_t;

  localparam pixel_t PIX_ZERO = 24'h000000;

endpackage

// File: rtl/dc_window_feeder_linebuf.sv
// One line of pixels: single write port, combinational read at the same column index.
module dc_linebuf_ram
  import dc_window_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [23:0]   i_wdata,
  output logic [23:0]   o_rdata
);

  pixel_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dc_window_feeder.sv
// Two-line window feeder: turns a raster RGB stream into top/mid/bot column words.
// Optional macro DC_WINDOW_BORDER_REPLICATE_EN: border rows replicate the nearest real row.
//
// state  | meaning
// LOAD0  | row 0 arriving, stored only, no output
// STREAM | rows 1..H-1 arriving, one column emitted per accepted pixel
// FLUSH  | input held off, last centre row emitted from the line buffers
module dc_window_feeder
  import dc_window_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_vld,
  input  logic [23:0] i_pix_data,
  output logic        o_pix_busy,
  output logic        o_rgb_vld,
  output logic [23:0] o_rgb_data,
  input  logic        i_rgb_busy
);

  localparam logic [1:0] ST_LOAD0  = LOAD0;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_FLUSH  = FLUSH;

  logic [1:0]    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_col_full;
  word_t         r_word;
  pixel_t        r_top, r_mid, r_bot;
  logic          r_ptr;
  logic          r_last;

  logic   w_busy, w_in_xfer, w_out_xfer, w_x_end, w_we;
  pixel_t w_rd_a, w_rd_b, w_mid, w_old;
  pixel_t w_pad_top, w_pad_bot, w_top_in, w_mid_in, w_bot_in;

  // r_ptr=0: LB_A holds row y-1, LB_B holds row y-2 (the one being overwritten)
  dc_linebuf_ram #(.DEPTH(IMG_W), .AW(XW)) u_lb_a (
    .i_clk  (i_clk),
    .i_we   (w_we && r_ptr),
    .i_addr (r_x),
    .i_wdata(i_pix_data),
    .o_rdata(w_rd_a)
  );

  dc_linebuf_ram #(.DEPTH(IMG_W), .AW(XW)) u_lb_b (
    .i_clk  (i_clk),
    .i_we   (w_we && !r_ptr),
    .i_addr (r_x),
    .i_wdata(i_pix_data),
    .o_rdata(w_rd_b)
  );

  assign w_mid = r_ptr ? w_rd_b : w_rd_a;
  assign w_old = r_ptr ? w_rd_a : w_rd_b;

`ifdef DC_WINDOW_BORDER_REPLICATE_EN
  assign w_pad_top = w_mid;
  assign w_pad_bot = w_mid;
`else
  assign w_pad_top = PIX_ZERO;
  assign w_pad_bot = PIX_ZERO;
`endif

  always_comb begin
    case (r_state)
      ST_LOAD0:  w_busy = 1'b0;
      ST_STREAM: w_busy = r_col_full;
      default:   w_busy = 1'b1;
    endcase
  end

  assign o_pix_busy = w_busy;
  assign w_in_xfer  = i_pix_vld && !w_busy;
  assign w_we       = w_in_xfer;
  assign w_out_xfer = r_col_full && !i_rgb_busy;
  assign w_x_end    = (r_x == XW'(IMG_W - 1));

  always_comb begin
    w_top_in = w_old;
    w_mid_in = w_mid;
    w_bot_in = i_pix_data;
    if (r_state == ST_STREAM && r_y == YW'(1)) w_top_in = w_pad_top;
    if (r_state == ST_FLUSH) w_bot_in = w_pad_bot;
  end

  always_comb begin
    case (r_word)
      TOP:     o_rgb_data = r_top;
      MID:     o_rgb_data = r_mid;
      default: o_rgb_data = r_bot;
    endcase
  end

  assign o_rgb_vld = r_col_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_LOAD0;
      r_x        <= '0;
      r_y        <= '0;
      r_col_full <= 1'b0;
      r_word     <= TOP;
      r_top      <= PIX_ZERO;
      r_mid      <= PIX_ZERO;
      r_bot      <= PIX_ZERO;
      r_ptr      <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      if (w_out_xfer) begin
        case (r_word)
          TOP: r_word <= MID;
          MID: r_word <= BOT;
          default: begin
            r_word     <= TOP;
            r_col_full <= 1'b0;
            if (r_state == ST_FLUSH && r_last) begin
              r_state <= ST_LOAD0;
              r_x     <= '0;
              r_y     <= '0;
              r_last  <= 1'b0;
            end
          end
        endcase
      end

      // loading a column requires !r_col_full, so it never collides with the BOT transfer above
      case (r_state)
        ST_LOAD0: begin
          if (w_in_xfer) begin
            if (w_x_end) begin
              r_x     <= '0;
              r_y     <= YW'(1);
              r_ptr   <= ~r_ptr;
              r_state <= ST_STREAM;
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (w_in_xfer) begin
            r_top      <= w_top_in;
            r_mid      <= w_mid_in;
            r_bot      <= w_bot_in;
            r_col_full <= 1'b1;
            if (w_x_end) begin
              r_x   <= '0;
              r_ptr <= ~r_ptr;
              if (r_y == YW'(IMG_H - 1)) begin
                r_y     <= YW'(IMG_H);
                r_state <= ST_FLUSH;
              end else begin
                r_y <= r_y + YW'(1);
              end
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!r_col_full && !r_last) begin
            r_top      <= w_top_in;
            r_mid      <= w_mid_in;
            r_bot      <= w_bot_in;
            r_col_full <= 1'b1;
            if (w_x_end) r_last <= 1'b1;
            else         r_x    <= r_x + XW'(1);
          end
        end
        default: r_state <= ST_LOAD0;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_window_feeder.sv
// Directed bench for dc_window_feeder at IMG_W=4, IMG_H=3, pixel = 16*y+x.
module tb_dc_window_feeder;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NW = 3 * W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_vld;
  logic [23:0] pix_data;
  logic        pix_busy;
  logic        rgb_vld;
  logic [23:0] rgb_data;
  logic        rgb_busy;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          c0;
  logic        vld_seen;
  logic [23:0] q[$];

  dc_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_pix_vld (pix_vld),
    .i_pix_data(pix_data),
    .o_pix_busy(pix_busy),
    .o_rgb_vld (rgb_vld),
    .o_rgb_data(rgb_data),
    .i_rgb_busy(rgb_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // values seen at the falling edge are what transfers on the next rising edge
  always @(negedge clk) begin
    if (rgb_vld) vld_seen = 1'b1;
    if (!rst && rgb_vld && !rgb_busy) q.push_back(rgb_data);
  end

  function automatic logic [23:0] pix(int r, int x);
    return 24'(16 * r + x);
  endfunction

  // expected word k of a frame: column k/3 is centred on row c, word k%3 selects row c-1, c, c+1
  function automatic logic [23:0] exp_word(int k);
    int col = k / 3;
    int c   = col / W;
    int x   = col % W;
    int r   = c - 1 + (k % 3);
`ifdef DC_WINDOW_BORDER_REPLICATE_EN
    if (r < 0)  r = 0;
    if (r >= H) r = H - 1;
    return pix(r, x);
`else
    if (r < 0 || r >= H) return 24'h0;
    return pix(r, x);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    logic ok = 1'b0;
    pix_data = v;
    pix_vld  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!pix_busy) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    pix_vld = 1'b0;
    check($sformatf("push_accept_%h", v), 32'(ok), 32'd1);
  endtask

  task automatic push_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int x = 0; x < W; x++) push(pix(r, x));
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 600 && q.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("word_count", 32'(q.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int base);
    for (int k = 0; k < NW; k++)
      check($sformatf("%s_w%0d", tag, k), 32'(q[base + k]), 32'(exp_word(k)));
  endtask

  initial begin
    rst      = 1'b1;
    pix_vld  = 1'b0;
    pix_data = 24'h0;
    rgb_busy = 1'b0;
    vld_seen = 1'b0;

    // reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rgb_vld", 32'(rgb_vld), 32'd0);
    check("rst_pix_busy", 32'(pix_busy), 32'd0);
    check("rst_rgb_data", 32'(rgb_data), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // row 0 streams in back-to-back without output
    q.delete();
    vld_seen = 1'b0;
    c0 = cyc;
    push_rows(0, 0);
    check("row0_cycles", 32'(cyc - c0), 32'd4);
    check("row0_no_vld", 32'(vld_seen), 32'd0);

    // rest of frame 1
    push_rows(1, 2);
    wait_words(NW);
    check("frame1_idle_busy", 32'(pix_busy), 32'd0);
    check("y1x0_top", 32'(q[0]), 32'h000000);
    check("y1x0_mid", 32'(q[1]), 32'h000000);
    check("y1x0_bot", 32'(q[2]), 32'h000010);
    check("flush_x3_top", 32'(q[33]), 32'h000013);
    check("flush_x3_mid", 32'(q[34]), 32'h000023);
`ifdef DC_WINDOW_BORDER_REPLICATE_EN
    check("y1x1_top", 32'(q[3]), 32'h000001);
    check("y1x1_mid", 32'(q[4]), 32'h000001);
    check("y1x1_bot", 32'(q[5]), 32'h000011);
    check("flush_x0_bot", 32'(q[26]), 32'h000020);
    check("flush_x3_bot", 32'(q[35]), 32'h000023);
`else
    check("y1x1_top", 32'(q[3]), 32'h000000);
    check("flush_x0_bot", 32'(q[26]), 32'h000000);
    check("flush_x3_bot", 32'(q[35]), 32'h000000);
`endif
    check_frame("frame1", 0);

    // frame 2 back-to-back, with a 5-cycle stall on the MID word of y=1,x=1
    push_rows(0, 0);
    push(pix(1, 0));
    push(pix(1, 1));
    @(posedge clk);
    #1;
    rgb_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_data", i), 32'(rgb_data), 32'(pix(0, 1)));
      check($sformatf("stall%0d_vld", i), 32'(rgb_vld), 32'd1);
      check($sformatf("stall%0d_pix_busy", i), 32'(pix_busy), 32'd1);
    end
    @(posedge clk);
    #1;
    rgb_busy = 1'b0;
    push(pix(1, 2));
    push(pix(1, 3));
    push_rows(2, 2);
    wait_words(2 * NW);
    check_frame("frame2", NW);

    // reset in the middle of STREAM y=1 x=2
    q.delete();
    push_rows(0, 0);
    push(pix(1, 0));
    push(pix(1, 1));
    push(pix(1, 2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rgb_vld", 32'(rgb_vld), 32'd0);
    check("midrst_pix_busy", 32'(pix_busy), 32'd0);
    @(posedge clk);
    #1;
    q.delete();
    push_rows(0, 2);
    wait_words(NW);
    check_frame("frame3", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
